// File: rtl/tri_job_scheduler_if.sv
// Avalon-MM bus between tri_job_scheduler (master) and its single isTriangle slave.
interface tri_job_scheduler_if #(
  parameter int AW = 2,
  parameter int DW = 32
) ();
  logic [AW-1:0] address;
  logic          write;
  logic          read;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          waitrequest;

  modport master (
    output address, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/tri_job_scheduler.sv
// Round-robin front end that runs (A,B,C) isTriangle jobs on one Avalon-MM slave.
// Define TRI_SCHED_TIMEOUT_EN to abort an access stalled for TIMEOUT_CYCLES cycles.
module tri_job_scheduler #(
  parameter int NREQ           = 2,
  parameter int AW             = 2,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*DW-1:0]   req_a_i,
  input  logic [NREQ*DW-1:0]   req_b_i,
  input  logic [NREQ*DW-1:0]   req_c_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic                 rsp_is_tri_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  tri_job_scheduler_if.master  m
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8 || AW < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("tri_job_scheduler: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_C, RD, RSP} state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic          write_q;
  logic          read_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] opb_q;
  logic [DW-1:0] opc_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic          rsp_is_tri_q;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [DW-1:0] sel_a, sel_b, sel_c;
  logic          timeout_hit;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot = NREQ'(1) << idx;
  endfunction

  // Two passes: indices above ptr outrank those at or below it; within a pass the lowest index wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (i <= int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (i > int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_a = req_a_i[i*DW +: DW];
        sel_b = req_b_i[i*DW +: DW];
        sel_c = req_c_i[i*DW +: DW];
      end
    end
  end

  assign req_ready_o = (state_q == IDLE && gnt_any) ? onehot(gnt_idx) : '0;

  // NOTE: operand holding registers carry no reset; they are always loaded at grant before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && gnt_any) begin
      opb_q <= sel_b;
      opc_q <= sel_c;
    end
  end

  // Each access: strobe rises after a one-cycle gap, holds until waitrequest is low at an edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NREQ - 1);
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_is_tri_q <= 1'b0;
    end else if (timeout_hit) begin
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= '0;
      rsp_valid_q  <= onehot(ptr_q);
      rsp_is_tri_q <= 1'b0;
      state_q      <= RSP;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            ptr_q   <= gnt_idx;
            wdata_q <= sel_a;
            write_q <= 1'b1;
            state_q <= WR_A;
          end
        end
        WR_A, WR_B, WR_C: begin
          if (!write_q) begin
            write_q <= 1'b1;
          end else if (!m.waitrequest) begin
            write_q <= 1'b0;
            addr_q  <= addr_q + AW'(1);
            case (state_q)
              WR_A:    begin wdata_q <= opb_q; state_q <= WR_B; end
              WR_B:    begin wdata_q <= opc_q; state_q <= WR_C; end
              default: state_q <= RD;
            endcase
          end
        end
        RD: begin
          if (!read_q) begin
            read_q <= 1'b1;
          end else if (!m.waitrequest) begin
            read_q       <= 1'b0;
            addr_q       <= '0;
            rsp_is_tri_q <= (m.readdata == DW'(1));
            rsp_valid_q  <= onehot(ptr_q);
            state_q      <= RSP;
          end
        end
        RSP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TRI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          rsp_err_q;

  assign timeout_hit = (write_q | read_q) & m.waitrequest &
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (!(write_q | read_q) || !m.waitrequest || timeout_hit) wait_cnt_q <= '0;
      else                                                     wait_cnt_q <= wait_cnt_q + TW'(1);
      if (timeout_hit)                                         rsp_err_q <= 1'b1;
      else if (state_q == RD && read_q && !m.waitrequest)      rsp_err_q <= 1'b0;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_is_tri_o = rsp_is_tri_q;
  assign busy_o       = (state_q != IDLE);
  assign m.address    = addr_q;
  assign m.write      = write_q;
  assign m.read       = read_q;
  assign m.writedata  = wdata_q;

endmodule

// File: tb/tb_tri_job_scheduler.sv
// Scoreboard bench for tri_job_scheduler: expected grants, bus transfers and responses are queued
// by the stimulus and consumed by a negedge monitor. Covers TRI_SCHED_TIMEOUT_EN on or off.
module tb_tri_job_scheduler;
  localparam int NREQ = 2;
  localparam int AW   = 2;
  localparam int DW   = 32;
  localparam int TOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_is_tri, rsp_err, busy;

  tri_job_scheduler_if #(.AW(AW), .DW(DW)) bus ();

  tri_job_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_c_i      (req_c),
    .rsp_valid_o  (rsp_valid),
    .rsp_is_tri_o (rsp_is_tri),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .m            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct {
    int   owner;
    logic is_tri;
    logic err;
    int   lat;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    gq[$];
  int    gnt_cyc[NREQ];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    xfer_count = 0;

  logic [DW-1:0] jt [2][3][3];

  // Slave model: waitrequest high for the first stall_len cycles of an access to stall_addr.
  logic [AW-1:0] stall_addr = '0;
  int            stall_len = 0;
  int            stall_cnt = 0;
  logic [DW-1:0] rd_val = '0;

  always_comb bus.waitrequest = (bus.write || bus.read) && (bus.address == stall_addr) &&
                                (stall_cnt < stall_len);
  assign bus.readdata = rd_val;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!(bus.write || bus.read)) stall_cnt <= 0;
    else if (bus.waitrequest)     stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Monitor: protocol rules plus scoreboard pops for grants, transfers and responses.
  logic          p_pend = 1'b0, p_rst = 1'b1, p_write = 1'b0, p_read = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.write || bus.read) check("rw_exclusive", bus.write & bus.read, 1'b0);
      if (bus.address !== p_addr) check("addr_change_while_idle", bus.write | bus.read, 1'b0);
      if (p_pend && !p_rst && (bus.write || bus.read)) begin
        check("hold_kind", {bus.write, bus.read}, {p_write, p_read});
        check("hold_addr", bus.address, p_addr);
        if (bus.write) check("hold_wdata", bus.writedata, p_wdata);
      end
`ifndef TRI_SCHED_TIMEOUT_EN
      if (p_pend && !p_rst) check("hold_strobe", bus.write | bus.read, 1'b1);
`endif
      if ((bus.write || bus.read) && !bus.waitrequest) begin
        xfer_count++;
        if (xq.size() == 0) fail("xfer_unexpected", $sformatf("addr %0d", bus.address));
        else begin
          xfer_t x;
          x = xq.pop_front();
          check("xfer_kind", bus.write, x.wr);
          check("xfer_addr", bus.address, x.addr);
          if (x.wr) check("xfer_wdata", bus.writedata, x.data);
        end
      end
      if (req_ready != '0) begin
        if (gq.size() == 0) fail("grant_unexpected", $sformatf("req_ready %b", req_ready));
        else begin
          int g;
          g = gq.pop_front();
          check("grant_owner", req_ready, NREQ'(1) << g);
          check("busy_at_grant", busy, 1'b0);
          gnt_cyc[g] = cyc;
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) fail("rsp_unexpected", $sformatf("rsp_valid %b", rsp_valid));
        else begin
          rsp_t e;
          e = rq.pop_front();
          check("rsp_owner", rsp_valid, NREQ'(1) << e.owner);
          check("rsp_is_tri", rsp_is_tri, e.is_tri);
          check("rsp_err", rsp_err, e.err);
          check("rsp_latency", cyc - gnt_cyc[e.owner], e.lat);
        end
      end
    end
    p_rst   <= reset;
    p_pend  <= (bus.write || bus.read) && bus.waitrequest;
    p_write <= bus.write;
    p_read  <= bus.read;
    p_addr  <= bus.address;
    p_wdata <= bus.writedata;
  end

  task automatic set_req(input int r, input logic [DW-1:0] a, b, c);
    req_a[r*DW +: DW] = a;
    req_b[r*DW +: DW] = b;
    req_c[r*DW +: DW] = c;
  endtask

  task automatic push_writes(input logic [DW-1:0] a, b, c);
    xq.push_back('{wr: 1'b1, addr: 2'd0, data: a});
    xq.push_back('{wr: 1'b1, addr: 2'd1, data: b});
    xq.push_back('{wr: 1'b1, addr: 2'd2, data: c});
  endtask

  task automatic wait_grant(input int r);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[r] && t < 50);
    if (!req_ready[r]) fail("grant_timeout", $sformatf("requester %0d", r));
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while ((rq.size() != 0 || gq.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) fail("done_timeout", $sformatf("rq %0d gq %0d busy %0b", rq.size(), gq.size(), busy));
    check("xfer_queue_drained", xq.size(), 0);
  endtask

  // One job on requester r; rd is what the slave returns, lat the expected grant-to-response gap.
  task automatic job(input int r, input logic [DW-1:0] a, b, c, rd,
                     input logic exp_tri, input int lat);
    @(posedge clk); #1;
    rd_val = rd;
    push_writes(a, b, c);
    xq.push_back('{wr: 1'b0, addr: 2'd3, data: '0});
    gq.push_back(r);
    rq.push_back('{owner: r, is_tri: exp_tri, err: 1'b0, lat: lat});
    set_req(r, a, b, c);
    req_valid[r] = 1'b1;
    wait_grant(r);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wait_done(200);
  endtask

  // Both requesters hold req_valid for per jobs each, starting at table slot base; slave returns 1.
  task automatic dual(input int base, input int per);
    int n[2];
    logic [NREQ-1:0] g;
    n[0] = 0;
    n[1] = 0;
    @(posedge clk); #1;
    rd_val = 32'd1;
    for (int k = 0; k < per; k++) begin
      for (int r = 0; r < 2; r++) begin
        gq.push_back(r);
        push_writes(jt[r][base+k][0], jt[r][base+k][1], jt[r][base+k][2]);
        xq.push_back('{wr: 1'b0, addr: 2'd3, data: '0});
        rq.push_back('{owner: r, is_tri: 1'b1, err: 1'b0, lat: 8});
      end
    end
    for (int r = 0; r < 2; r++) set_req(r, jt[r][base][0], jt[r][base][1], jt[r][base][2]);
    req_valid = 2'b11;
    for (int t = 0; t < 400 && (n[0] < per || n[1] < per); t++) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (g[r]) begin
          n[r]++;
          if (n[r] < per) set_req(r, jt[r][base+n[r]][0], jt[r][base+n[r]][1], jt[r][base+n[r]][2]);
          else            req_valid[r] = 1'b0;
        end
      end
    end
    if (n[0] < per || n[1] < per) fail("dual_timeout", $sformatf("grants %0d/%0d", n[0], n[1]));
    wait_done(300);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    jt[0][0] = '{32'd3, 32'd4, 32'd5};
    jt[0][1] = '{32'd6, 32'd8, 32'd10};
    jt[0][2] = '{32'd3, 32'd4, 32'd5};
    jt[1][0] = '{32'd5, 32'd5, 32'd5};
    jt[1][1] = '{32'd2, 32'd3, 32'd4};
    jt[1][2] = '{32'd1, 32'd1, 32'd3};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_write", bus.write, 1'b0);
    check("reset_read", bus.read, 1'b0);
    check("reset_address", bus.address, '0);
    check("reset_rsp_is_tri", rsp_is_tri, 1'b0);
    check("reset_rsp_err", rsp_err, 1'b0);

    // Single job, triangle
    job(0, 32'd3, 32'd4, 32'd5, 32'd1, 1'b1, 8);

    // Non-triangle: exactly four bus transfers
    n0 = xfer_count;
    job(0, 32'd1, 32'd2, 32'd10, 32'd0, 1'b0, 8);
    check("non_tri_xfer_count", xfer_count - n0, 4);

    // Readdata other than exactly 1 is not a triangle
    job(1, 32'd3, 32'd4, 32'd5, 32'd3, 1'b0, 8);

    // Contention: grants alternate 0,1,0,1
    dual(0, 2);

    // Waitrequest held 3 cycles on the B write
    stall_addr = 2'd1;
    stall_len  = 3;
    job(1, 32'd2, 32'd2, 32'd3, 32'd1, 1'b1, 11);
    stall_len  = 0;

    // Reset while the read is stalled; job discarded, pointer back to NREQ-1
    @(posedge clk); #1;
    stall_addr = 2'd3;
    stall_len  = 1000;
    push_writes(32'd7, 32'd8, 32'd9);
    gq.push_back(0);
    set_req(0, 32'd7, 32'd8, 32'd9);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n0 = 0;
    while (!bus.read && n0 < 50) begin
      @(negedge clk);
      n0++;
    end
    if (!bus.read) fail("read_phase_timeout", "read never asserted");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stall_len = 0;
    @(negedge clk);
    check("mid_reset_read_dropped", bus.read, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_no_rsp", rsp_valid, '0);
    check("mid_reset_xq_empty", xq.size(), 0);
    dual(2, 1);

    // Stalled A write: timeout abort, or indefinite wait without the timeout
`ifdef TRI_SCHED_TIMEOUT_EN
    @(posedge clk); #1;
    stall_addr = 2'd0;
    stall_len  = 1000;
    rd_val     = 32'd1;
    gq.push_back(0);
    rq.push_back('{owner: 0, is_tri: 1'b0, err: 1'b1, lat: TOUT + 1});
    set_req(0, 32'd3, 32'd4, 32'd5);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_done(100);
    check("timeout_write_dropped", bus.write, 1'b0);
    stall_len = 0;
`else
    @(posedge clk); #1;
    stall_addr = 2'd0;
    stall_len  = 1000;
    gq.push_back(0);
    set_req(0, 32'd3, 32'd4, 32'd5);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("stuck_busy", busy, 1'b1);
    check("stuck_write", bus.write, 1'b1);
    check("stuck_address", bus.address, 2'd0);
    check("stuck_rsp_err", rsp_err, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stall_len = 0;
    @(negedge clk);
    check("stuck_reset_busy", busy, 1'b0);
    check("stuck_reset_write", bus.write, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("final_rq_empty", rq.size(), 0);
    check("final_gq_empty", gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
